// File: rtl/turn_signal_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : turn_signal_scheduler
// Purpose  : Tail-light sequencer producing PWM duties for a three-lamp sweep
//            per side, with hazard/turn arbitration and a brake dim overlay.
// Revision : 1.0 - initial release
// ============================================================================
module turn_signal_scheduler #(
  parameter int          TICK_DIV = 25_000_000,
  parameter logic [7:0]  DUTY_ON  = 8'hFF,
  parameter logic [7:0]  DUTY_DIM = 8'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        left,
  input  logic        right,
  input  logic        hazard,
  input  logic        brake,
  output logic [23:0] duty_l,
  output logic [23:0] duty_r,
  output logic        busy,
  output logic [1:0]  side
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    mode, mode_nxt;
  logic [1:0]    lit_nxt;

  // Lamps 0..lit-1 of an active side are lit; everything else falls back to brake dim.
  function automatic logic [23:0] side_duty(input logic active, input logic [1:0] lit,
                                            input logic brk);
    logic [23:0] d;
    d = '0;
    for (int i = 0; i < 3; i++) begin
      if (active && (i < int'(lit)))
        d[i*8 +: 8] = DUTY_ON;
      else if (brk)
        d[i*8 +: 8] = DUTY_DIM;
      else
        d[i*8 +: 8] = 8'h00;
    end
    return d;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode;
    if (state == IDLE) begin
      cnt_nxt = '0;
      if (hazard) begin
        mode_nxt  = 2'b11;
        state_nxt = S1;
      end else if (left ^ right) begin
        mode_nxt  = {left, right};
        state_nxt = S1;
      end else begin
        mode_nxt  = 2'b00;
      end
    end else if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      case (state)
        S1:      state_nxt = S2;
        S2:      state_nxt = S3;
        S3:      state_nxt = GAP;
        default: begin
          state_nxt = IDLE;
          mode_nxt  = 2'b00;
        end
      endcase
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_comb begin
    case (state_nxt)
      S1:      lit_nxt = 2'd1;
      S2:      lit_nxt = 2'd2;
      S3:      lit_nxt = 2'd3;
      default: lit_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mode   <= 2'b00;
      duty_l <= '0;
      duty_r <= '0;
      busy   <= 1'b0;
      side   <= 2'b00;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode   <= mode_nxt;
      duty_l <= side_duty(mode_nxt[1], lit_nxt, brake);
      duty_r <= side_duty(mode_nxt[0], lit_nxt, brake);
      busy   <= (state_nxt != IDLE);
      side   <= mode_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_turn_signal_scheduler.sv
`default_nettype none
// Testbench for turn_signal_scheduler: directed scenarios plus random traffic,
// checked every cycle against a time-since-start reference model.
module tb_turn_signal_scheduler;

  localparam int         TD  = 4;
  localparam logic [7:0] ON  = 8'hFF;
  localparam logic [7:0] DIM = 8'h40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;
  logic [23:0] duty_l, duty_r;
  logic        busy;
  logic [1:0]  side;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // Reference model: a sequence is just "cycles elapsed since start" plus the mode.
  bit       m_active = 0;
  int       m_t      = 0;
  logic [1:0] m_mode = 2'b00;
  bit       m_brk    = 0;

  turn_signal_scheduler #(.TICK_DIV(TD), .DUTY_ON(ON), .DUTY_DIM(DIM)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
    .brake(brake), .duty_l(duty_l), .duty_r(duty_r), .busy(busy), .side(side)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] exp_duty(input bit on_side);
    logic [23:0] d;
    int lit;
    lit = 0;
    if (m_active && (m_t / TD) < 3) lit = m_t / TD + 1;
    for (int i = 0; i < 3; i++)
      d[i*8 +: 8] = (on_side && i < lit) ? ON : (m_brk ? DIM : 8'h00);
    return d;
  endfunction

  task automatic model_edge();
    if (!m_active) begin
      if (hazard) begin
        m_active = 1; m_mode = 2'b11; m_t = 0;
      end else if (left ^ right) begin
        m_active = 1; m_mode = {left, right}; m_t = 0;
      end
    end else begin
      m_t++;
      if (m_t == 4 * TD) begin
        m_active = 0; m_mode = 2'b00;
      end
    end
    m_brk = brake;
  endtask

  task automatic model_reset();
    m_active = 0; m_t = 0; m_mode = 2'b00; m_brk = 0;
  endtask

  task automatic compare();
    check("duty_l", {8'h0, duty_l}, {8'h0, exp_duty(m_mode[1])});
    check("duty_r", {8'h0, duty_r}, {8'h0, exp_duty(m_mode[0])});
    check("busy",   {31'h0, busy},  {31'h0, m_active});
    check("side",   {30'h0, side},  {30'h0, m_mode});
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (reset) model_edge();
    #1;
    compare();
  endtask

  // Entered just after an edge: assert reset between edges, hold across one edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    model_reset();
    #1 compare();
    @(posedge clk);
    cyc++;
    #1 compare();
    #2 reset = 1'b1;
  endtask

  logic [23:0] lp_tbl [4];
  int start_r;
  bit found;

  initial begin
    lp_tbl[0] = 24'h0000FF; lp_tbl[1] = 24'h00FFFF;
    lp_tbl[2] = 24'hFFFFFF; lp_tbl[3] = 24'h000000;

    #3 reset = 1'b0;
    model_reset();
    #1 compare();
    @(posedge clk); #1 compare();
    #2 reset = 1'b1;
    repeat (3) step();

    // One-cycle left pulse
    left = 1; step(); left = 0;
    check("lp_s1", {8'h0, duty_l}, {8'h0, lp_tbl[0]});
    for (int i = 1; i < 16; i++) begin
      step();
      check("lp_duty_l", {8'h0, duty_l}, {8'h0, lp_tbl[i/4]});
      check("lp_duty_r", {8'h0, duty_r}, 32'h0);
      check("lp_side", {30'h0, side}, 32'h2);
      check("lp_busy", {31'h0, busy}, 32'h1);
    end
    step();
    check("lp_idle", {31'h0, busy}, 32'h0);

    // Conflicting left+right, then hazard
    left = 1; right = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("lr_nostart", {31'h0, busy}, 32'h0);
    end
    hazard = 1; step();
    check("hz_side", {30'h0, side}, 32'h3);
    hazard = 0; left = 0; right = 0;
    repeat (17) step();

    // Brake through a right sweep, dropped in GAP
    brake = 1; right = 1; step(); right = 0;
    check("br_r_s1", {8'h0, duty_r}, 32'h4040FF);
    check("br_l_s1", {8'h0, duty_l}, 32'h404040);
    repeat (13) step();
    brake = 0; step();
    check("br_gap_off", {8'h0, duty_r}, 32'h0);
    repeat (3) step();

    // Right held, switched to left during S3
    right = 1; step(); start_r = cyc;
    repeat (9) step();
    right = 0; left = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (side == 2'b10) found = 1;
    end
    check("rl_restart", cyc - start_r, 32'd17);
    left = 0;
    repeat (17) step();

    // Reset mid-S2 of a left sweep
    left = 1; step(); left = 0;
    repeat (5) step();
    do_reset();
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_duty_l", {8'h0, duty_l}, 32'h0);
    repeat (4) step();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        left   = ($urandom_range(0, 2) == 0);
        right  = ($urandom_range(0, 2) == 0);
        hazard = ($urandom_range(0, 7) == 0);
        brake  = ($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
